// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MIPS multiply/divide unit owning HI/LO
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, op       : EX-stage mul/div request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa, opb        : rs / rt operands
//   flush           : EX-stage squash, aborts a running operation
//   mthi, mtlo      : write opa into HI / LO when idle
//   hilo_rd         : MFHI/MFLO present in EX
//   hi, lo          : HI / LO registers
//   busy, done      : operation in flight / result written this cycle
//   stall_req       : freeze IF/ID/EX while a dependent instruction waits
module muldiv_sequencer #(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         flush,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic         hilo_rd,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         stall_req
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     x_q, x_d;       // |multiplicand| or |dividend| (dividend shifts out MSB-first)
  logic [W-1:0]     y_q, y_d;       // |multiplier| (shifts right) or |divisor| (static)
  logic [W-1:0]     opa_q, opa_d;   // raw dividend, returned as HI on divide-by-zero
  logic [2*W-1:0]   acc_q, acc_d;   // mul: product; div: {remainder, quotient}
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic           in_signed, a_neg, b_neg;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_ext, trial;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] product;
  logic [W-1:0]   quot_fix, rem_fix;

  assign in_signed = ~op[0];
  assign a_neg     = in_signed & opa[W-1];
  assign b_neg     = in_signed & opb[W-1];
  assign abs_a     = a_neg ? -opa : opa;
  assign abs_b     = b_neg ? -opb : opb;

  // Shift-add: the W+1-bit sum keeps the carry that the right shift pulls into the top.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (y_q[0] ? {1'b0, x_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring step: the shifted remainder needs W+1 bits; a set MSB of the
  // W+1-bit difference means the trial went negative and is discarded.
  assign rem_ext  = {acc_q[2*W-1:W], x_q[W-1]};
  assign trial    = rem_ext - {1'b0, y_q};
  assign div_next = {(trial[W] ? rem_ext[W-1:0] : trial[W-1:0]), acc_q[W-2:0], ~trial[W]};

  assign product  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          // An accepted start drops any move-to-HI/LO in the same cycle.
          x_d      = abs_a;
          y_d      = abs_b;
          opa_d    = opa;
          acc_d    = '0;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          state_d  = S_CALC;
        end else begin
          if (mthi) hi_d = opa;
          if (mtlo) lo_d = opa;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = div_next;
            x_d   = {x_q[W-2:0], 1'b0};
          end else begin
            acc_d = mul_next;
            y_d   = {1'b0, y_q[W-1:1]};
          end
          if (cnt_q == CNT_LAST) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (!is_div_q) begin
            hi_d = product[2*W-1:W];
            lo_d = product[W-1:0];
          end else if (y_q == '0) begin
            hi_d = opa_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIXUP) && !flush && !reset;
  assign stall_req = busy && (start || hilo_rd || mthi || mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed vector bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, flush, mthi, mtlo, hilo_rd;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [31:0] hi, lo;
  logic        busy, done, stall_req;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.W(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .hilo_rd(hilo_rd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one op, returns the cycle index (1 = first cycle after the accepting
  // edge) in which done was seen and the number of busy cycles; returns #1
  // after the edge that writes HI/LO.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    bit found;
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0; found = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        found = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, bcnt, scnt, dcnt;
    bit idle_seen, found;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIVU,  32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};

    reset = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
    op = 2'b00; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_stall", {31'b0, stall_req}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd33);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_busy_after", i), {31'b0, busy}, 32'h0);
    end

    // Start and MFHI held while busy: stalled every busy cycle, then taken in IDLE.
    @(negedge clk);
    op = OP_DIVU; opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 op = OP_MULTU; opa = 32'd6; opb = 32'd7; hilo_rd = 1'b1;
    scnt = 0; idle_seen = 0;
    for (int i = 0; i < 60 && !idle_seen; i++) begin
      @(negedge clk);
      if (busy) begin
        if (stall_req) scnt++;
      end else begin
        idle_seen = 1;
      end
    end
    check("stall_cycles", 32'(scnt), 32'd33);
    check("stall_idle", {31'b0, stall_req}, 32'h0);
    check("stall_first_hi", hi, 32'd2);
    check("stall_first_lo", lo, 32'd14);
    @(posedge clk);
    #1 start = 1'b0; hilo_rd = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("stall_second_done", {31'b0, found}, 32'h1);
    @(posedge clk);
    #1;
    check("stall_second_hi", hi, 32'd0);
    check("stall_second_lo", lo, 32'd42);

    // mthi in the same IDLE cycle as start: start wins, HI untouched.
    @(negedge clk);
    op = OP_MULTU; opa = 32'd3; opb = 32'd4; start = 1'b1; mthi = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mthi = 1'b0;
    check("mthi_start_hi", hi, 32'd0);
    check("mthi_start_busy", {31'b0, busy}, 32'h1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    @(posedge clk);
    #1;
    check("mthi_start_lo", lo, 32'd12);

    // MTHI/MTLO in IDLE, then a flushed MULT leaves both untouched.
    @(negedge clk);
    opa = 32'hAA; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; opa = 32'h55; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mthi_hi", hi, 32'hAA);
    check("mtlo_lo", lo, 32'h55);
    op = OP_MULT; opa = 32'd2; opb = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("flush_no_done", 32'(dcnt), 32'd0);
    check("flush_hi", hi, 32'hAA);
    check("flush_lo", lo, 32'h55);

    // Reset in CALC cycle 5 wins over the running operation.
    @(negedge clk);
    op = OP_MULTU; opa = 32'd9; opb = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_done", {31'b0, done}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
